// File: rtl/mem_port_sequencer.sv
// Shares one single-ported memory between instruction fetch and load/store,
// sequencing each access through a ready handshake and raising pipeline stalls.
module mem_port_sequencer #(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_be,
  output logic [31:0]       d_rdata,
  output logic              d_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              stall_if,
  output logic              stall_mem
);

  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              d_valid_q, d_valid_d;
  logic              grant_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      starve_q    <= 4'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      mem_be_q    <= 4'h0;
      if_rdata_q  <= 32'd0;
      d_rdata_q   <= 32'd0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    // Data wins ties until the fetch has been passed over STARVE_MAX times.
    grant_d     = d_req & ~(if_req & (starve_q == STARVE_LIM));
    unique case (state_q)
      IDLE: begin
        if (!if_req) starve_d = 4'd0;
        if (grant_d) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_be_d    = d_we ? d_be : 4'hF;
          if (if_req && (starve_q != STARVE_LIM)) starve_d = starve_q + 4'd1;
        end else if (if_req) begin
          state_d    = BUSY_I;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
          mem_be_d   = 4'hF;
          starve_d   = 4'd0;
        end
      end
      BUSY_I: begin
        if (mem_ready) begin
          if_rdata_d = mem_rdata;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          if_valid_d = 1'b1;
          state_d    = RESP_I;
        end
      end
      BUSY_D: begin
        if (mem_ready) begin
          if (!mem_we_q) d_rdata_d = mem_rdata;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          d_valid_d = 1'b1;
          state_d   = RESP_D;
        end
      end
      RESP_I, RESP_D: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign stall_if  = if_req & ~if_valid_q;
  assign stall_mem = d_req & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Directed bench for mem_port_sequencer: transaction-level reference model
// compared every cycle, plus literal expectations for each scenario.
module tb_mem_port_sequencer;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst, if_req, d_req, d_we, mem_ready;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_be;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_valid, d_valid, mem_req, mem_we, stall_if, stall_mem;
  logic [3:0]  mem_be;

  mem_port_sequencer #(.ADDR_W(32), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Bench memory and responder controls
  logic [31:0] bmem [0:255];
  int ready_delay = 0;
  int wait_cnt = 0;
  bit force_ready = 1'b0;

  // Reference model: one outstanding transaction, tracked by phase
  int          m_phase = 0;   // 0 free, 1 memory access outstanding, 2 response cycle
  bit          m_data, m_store;
  int          m_starve = 0;
  logic        e_req, e_we, e_ifv, e_dv;
  logic [31:0] e_addr, e_wdata, e_ifr, e_dr;
  logic [3:0]  e_be;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("mem_req",   32'(mem_req),   32'(e_req));
    chk("mem_we",    32'(mem_we),    32'(e_we));
    chk("mem_addr",  mem_addr,       e_addr);
    chk("mem_wdata", mem_wdata,      e_wdata);
    chk("mem_be",    32'(mem_be),    32'(e_be));
    chk("if_rdata",  if_rdata,       e_ifr);
    chk("if_valid",  32'(if_valid),  32'(e_ifv));
    chk("d_rdata",   d_rdata,        e_dr);
    chk("d_valid",   32'(d_valid),   32'(e_dv));
    chk("stall_if",  32'(stall_if),  32'(if_req & ~e_ifv));
    chk("stall_mem", 32'(stall_mem), 32'(d_req & ~e_dv));
  endtask

  task automatic respond();
    if (mem_req) begin
      if (wait_cnt >= ready_delay) begin
        mem_ready = 1'b1;
        if (mem_we) begin
          for (int b = 0; b < 4; b++)
            if (mem_be[b]) bmem[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
          mem_rdata = 32'hA5A5A5A5;
        end else begin
          mem_rdata = bmem[mem_addr[9:2]];
        end
      end else begin
        mem_ready = 1'b0;
        mem_rdata = 32'h0BAD0BAD;
      end
      wait_cnt++;
    end else begin
      wait_cnt  = 0;
      mem_ready = force_ready;
      mem_rdata = force_ready ? 32'hFFFFFFFF : 32'h0;
    end
  endtask

  task automatic model_step();
    bit take_d;
    if (rst) begin
      m_phase = 0; m_starve = 0;
      e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_be = 0;
      e_ifr = 0; e_dr = 0; e_ifv = 0; e_dv = 0;
    end else begin
      e_ifv = 0; e_dv = 0;
      if (m_phase == 0) begin
        take_d = d_req && !(if_req && m_starve == STARVE_MAX);
        if (!if_req) m_starve = 0;
        if (take_d) begin
          e_req = 1; e_we = d_we; e_addr = d_addr; e_wdata = d_wdata;
          e_be = d_we ? d_be : 4'hF;
          m_data = 1; m_store = d_we; m_phase = 1;
          if (if_req && m_starve < STARVE_MAX) m_starve++;
        end else if (if_req) begin
          e_req = 1; e_we = 0; e_addr = if_addr; e_be = 4'hF;
          m_data = 0; m_store = 0; m_phase = 1; m_starve = 0;
        end
      end else if (m_phase == 1) begin
        if (mem_ready) begin
          if (!m_data) e_ifr = mem_rdata;
          else if (!m_store) e_dr = mem_rdata;
          e_req = 0; e_we = 0;
          if (m_data) e_dv = 1; else e_ifv = 1;
          m_phase = 2;
        end
      end else begin
        m_phase = 0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (chk_en) compare_all();
    #1;
    respond();
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    string     exp_seq;
    logic [7:0] glog [0:9];
    int        gcnt;
    logic      prev_req;

    for (int i = 0; i < 256; i++) bmem[i] = 32'h0;
    bmem[32'h100 >> 2] = 32'h00500093;
    bmem[32'h104 >> 2] = 32'h00A00113;
    bmem[32'h80  >> 2] = 32'h12345678;
    bmem[32'h200 >> 2] = 32'h87654321;
    bmem[32'h300 >> 2] = 32'h11223344;
    bmem[32'h304 >> 2] = 32'h55667788;

    rst = 1; if_req = 0; d_req = 0; d_we = 0; if_addr = 0; d_addr = 0;
    d_wdata = 0; d_be = 0; mem_ready = 0; mem_rdata = 0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_valids", 32'({if_valid, d_valid}), 32'd0);
    rst = 0;
    tick();

    // Single fetch
    if_req = 1; if_addr = 32'h100; ready_delay = 0;
    tick();
    chk("f1_mem_req", 32'(mem_req), 32'd1);
    chk("f1_mem_addr", mem_addr, 32'h100);
    chk("f1_mem_we", 32'(mem_we), 32'd0);
    chk("f1_stall_if", 32'(stall_if), 32'd1);
    tick();
    chk("f1_if_valid", 32'(if_valid), 32'd1);
    chk("f1_if_rdata", if_rdata, 32'h00500093);
    chk("f1_stall_if_rel", 32'(stall_if), 32'd0);
    if_req = 0;
    tick();

    // Store then load
    d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
    tick();
    chk("st_mem_we", 32'(mem_we), 32'd1);
    chk("st_mem_be", 32'(mem_be), 32'h3);
    chk("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    chk("st_d_valid", 32'(d_valid), 32'd1);
    chk("st_d_rdata", d_rdata, 32'h0);
    d_we = 0;
    tick();
    tick();
    chk("ld_mem_be", 32'(mem_be), 32'hF);
    chk("ld_mem_we", 32'(mem_we), 32'd0);
    tick();
    chk("ld_d_valid", 32'(d_valid), 32'd1);
    chk("ld_d_rdata", d_rdata, 32'h0000BEEF);
    d_req = 0;
    tick();

    // Contention: fetch forced through after STARVE_MAX data grants
    if_req = 1; if_addr = 32'h200; d_req = 1; d_we = 0; d_addr = 32'h80;
    gcnt = 0; prev_req = mem_req;
    for (int c = 0; c < 80 && gcnt < 10; c++) begin
      tick();
      if (mem_req && !prev_req) begin
        glog[gcnt] = (mem_addr == 32'h200) ? "I" : "D";
        gcnt++;
      end
      prev_req = mem_req;
    end
    if_req = 0; d_req = 0;
    chk("arb_grant_count", 32'(gcnt), 32'd10);
    exp_seq = "DDDDIDDDDI";
    for (int i = 0; i < 10; i++)
      if (i < gcnt) chk($sformatf("arb_grant_%0d", i), 32'(glog[i]), 32'(exp_seq[i]));
    tick(); tick(); tick();

    // Wait states with the fetch address changing mid-access
    if_req = 1; if_addr = 32'h300; ready_delay = 5;
    tick();
    if_addr = 32'h304;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("ws_mem_req", 32'(mem_req), 32'd1);
      chk("ws_mem_addr", mem_addr, 32'h300);
      chk("ws_if_valid", 32'(if_valid), 32'd0);
    end
    tick();
    chk("ws_if_valid_pulse", 32'(if_valid), 32'd1);
    chk("ws_if_rdata", if_rdata, 32'h11223344);
    if_req = 0; ready_delay = 0;
    tick();

    // Reset in the middle of a data access
    d_req = 1; d_we = 0; d_addr = 32'h80; ready_delay = 3;
    tick();
    chk("rm_busy", 32'(mem_req), 32'd1);
    rst = 1;
    tick();
    chk("rm_mem_req", 32'(mem_req), 32'd0);
    chk("rm_mem_addr", mem_addr, 32'h0);
    chk("rm_d_rdata", d_rdata, 32'h0);
    rst = 0; d_req = 0; ready_delay = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("rm_no_valid", 32'(d_valid), 32'd0);
    end
    d_req = 1;
    tick();
    chk("rm_regrant_addr", mem_addr, 32'h80);
    tick();
    chk("rm_regrant_valid", 32'(d_valid), 32'd1);
    chk("rm_regrant_data", d_rdata, 32'h12345678);
    d_req = 0;
    tick();

    // Back-to-back fetches
    if_req = 1; if_addr = 32'h100;
    tick();
    tick();
    chk("bb_first_valid", 32'(if_valid), 32'd1);
    if_addr = 32'h104;
    tick();
    chk("bb_gap", 32'(mem_req), 32'd0);
    tick();
    chk("bb_second_req", 32'(mem_req), 32'd1);
    chk("bb_second_addr", mem_addr, 32'h104);
    tick();
    chk("bb_second_data", if_rdata, 32'h00A00113);
    if_req = 0;
    tick();

    // Stray mem_ready while idle is ignored
    force_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("stray_valids", 32'({if_valid, d_valid}), 32'd0);
    end
    force_ready = 1'b0;
    tick();
    chk("stray_if_rdata", if_rdata, 32'h00A00113);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_port_sequencer.md
Name: mem_port_sequencer

Overview:
- Multi-cycle controller that shares one single-ported instruction/data memory between two requesters: instruction fetch (IF) and the load/store stage (MEM).
- Arbitrates between them, sequences each access through a ready-handshake memory port, and returns read data.
- Generates the stall signals that freeze the PC and pipeline registers around the core control unit while an access is pending.

Parameters:
- ADDR_W, 32, byte-address width of all address ports.
- STARVE_MAX, 4, consecutive data grants allowed while a fetch is pending before the fetch is forced to win (range 1..15).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request, level
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  32  fetched instruction, registered
- if_valid  out  1  one-cycle pulse: fetch complete
- d_req  in  1  data request, level
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  32  store data
- d_be  in  4  byte enables for stores
- d_rdata  out  32  load data, registered
- d_valid  out  1  one-cycle pulse: data access complete
- mem_req  out  1  memory access strobe, registered
- mem_we  out  1  memory write enable, registered
- mem_addr  out  ADDR_W  memory address, registered
- mem_wdata  out  32  memory write data, registered
- mem_be  out  4  memory byte enables, registered; 4'hF for fetches and loads
- mem_rdata  in  32  memory read data, valid when mem_ready=1
- mem_ready  in  1  memory completes the current access this cycle
- stall_if  out  1  combinational: if_req & ~if_valid
- stall_mem  out  1  combinational: d_req & ~d_valid

Behaviour:
- States: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D. Reset state is IDLE.
- Reset values:
  - mem_req, mem_we, if_valid, d_valid = 0.
  - mem_addr, mem_wdata, if_rdata, d_rdata = 0.
  - mem_be = 4'h0.
  - Starve counter = 0.
- IDLE arbitration, evaluated each cycle:
  - Only d_req: grant data.
  - Only if_req: grant fetch.
  - Both asserted: grant data unless the starve counter equals STARVE_MAX, in which case grant fetch.
  - Neither asserted: stay in IDLE.
- On a grant, at the next edge: state becomes BUSY_x, mem_req=1, and the requester's address/we/wdata/be are latched into the mem_* outputs.
- Fetch grants drive mem_we=0 and mem_be=4'hF. Load grants drive mem_be=4'hF.
- BUSY_x:
  - mem_* outputs are held stable while mem_ready=0; there is no timeout.
  - On mem_ready=1:
    - capture mem_rdata into if_rdata (fetch) or d_rdata (load); a store leaves d_rdata unchanged;
    - drop mem_req and mem_we;
    - move to RESP_x.
- RESP_x: the matching valid is 1 for exactly this cycle; the next state is IDLE.
- A request still asserted in the cycle after its valid pulse is treated as a new transaction.
- Latency: request seen in IDLE at cycle 0; mem_req=1 from cycle 1; with mem_ready in cycle k (k≥1), valid is asserted in cycle k+1. Minimum request-to-valid is 2 cycles, with 1 idle cycle between back-to-back accesses.
- Requesters hold req, addr and wdata stable until their valid pulse. Changes to inputs while BUSY are ignored.
- Starve counter:
  - increments on each data grant made while if_req=1, saturating at STARVE_MAX;
  - clears on any fetch grant;
  - clears on any IDLE cycle with if_req=0.
- stall_if and stall_mem are purely combinational, so the pipeline advances in the same cycle valid pulses.
- Reset mid-access: at the edge where rst=1, all state and outputs return to reset values. No valid pulse is generated, and the in-flight access is abandoned. The memory must tolerate mem_req dropping without a mem_ready.
- mem_ready asserted while IDLE or RESP_x is ignored.

Test Plan:
- Single fetch: if_req=1, if_addr=0x100, mem_ready 1 cycle after mem_req with mem_rdata=0x00500093 -> mem_addr=0x100, mem_we=0; if_valid pulses 2 cycles after the request with if_rdata=0x00500093; stall_if=1 until that pulse.
- Store then load: d_req, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, d_be=4'b0011, then a load from 0x40 returning 0x0000BEEF -> mem_we=1 and mem_be=4'b0011 during the store; d_rdata unchanged after the store; d_rdata=0x0000BEEF after the load.
- Contention with STARVE_MAX=4: if_req and d_req held high, each access 1-cycle ready -> grant sequence D,D,D,D,I,D,D,D,D,I; counter clears after each fetch grant.
- Wait states: mem_ready held low for 5 cycles on a fetch, with if_addr changed mid-access -> mem_req, mem_addr and mem_we stay stable; original-address data returned; if_valid 1 cycle after mem_ready.
- Reset mid-access: rst=1 for one cycle during BUSY_D -> next cycle mem_req=0, d_valid never pulses, state IDLE; a re-asserted d_req is re-granted normally.
- Back-to-back fetch: if_req held across an if_valid pulse with a new if_addr=0x104 -> a second access to 0x104 starts with mem_req rising 2 cycles after the first if_valid; no duplicate access to 0x100.
